// File: rtl/uart_ram_writer.sv
// Packs received UART bytes into 16-bit words (low byte first) and writes them
// to sequential cellular-RAM addresses using asynchronous write cycles.
module uart_ram_writer #(
  parameter int ADDR_W     = 26,
  parameter int END_ADDR   = 536000,
  parameter int WR_CYCLES  = 8,
  parameter int REC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] address,
  output logic [15:0]       dq_out,
  output logic              dq_oe,
  output logic              ce_n,
  output logic              we_n,
  output logic              oe_n,
  output logic              ub_n,
  output logic              lb_n,
  output logic              adv_n,
  output logic              cre,
  output logic              ram_clk,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] REC   = 3'd4;

  localparam int MAX_CYC = (WR_CYCLES > REC_CYCLES) ? WR_CYCLES : REC_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [2:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              phase_r;
  logic [7:0]        lowByte_r;
  logic              pending_r;
  logic [15:0]       holdWord_r;

  logic              byteEvt_s;
  logic              wordDone_s;
  logic              isIdle_s;
  logic              takeWord_s;
  logic              dropWord_s;
  logic              startWr_s;
  logic [ADDR_W-1:0] nextAddr_s;

  assign byteEvt_s  = rx_valid & en & ~done;
  assign wordDone_s = byteEvt_s & phase_r;
  assign isIdle_s   = (state_r == IDLE);
  // A word completing while IDLE hands off is safe: the register empties this cycle.
  assign takeWord_s = wordDone_s & (isIdle_s | ~pending_r);
  assign dropWord_s = wordDone_s & ~isIdle_s & pending_r;
  assign startWr_s  = isIdle_s & pending_r & ~done;
  assign nextAddr_s = address + ADDR_W'(1);

  // Async-mode pins and output enable are fixed.
  assign oe_n    = 1'b1;
  assign adv_n   = 1'b0;
  assign cre     = 1'b0;
  assign ram_clk = 1'b0;

  // Byte assembler: pairs bytes, dropping a half pair whenever en goes low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r   <= 1'b0;
      lowByte_r <= 8'h00;
    end else if (!en) begin
      phase_r <= 1'b0;
    end else if (byteEvt_s) begin
      if (!phase_r) begin
        lowByte_r <= rx_data;
        phase_r   <= 1'b1;
      end else begin
        phase_r <= 1'b0;
      end
    end else begin
      phase_r <= phase_r;
    end
  end

  // Holding register, write-cycle sequencer and registered RAM strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      pending_r  <= 1'b0;
      holdWord_r <= 16'h0000;
      overrun    <= 1'b0;
      address    <= '0;
      dq_out     <= 16'h0000;
      dq_oe      <= 1'b0;
      ce_n       <= 1'b1;
      we_n       <= 1'b1;
      ub_n       <= 1'b1;
      lb_n       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (takeWord_s) begin
        holdWord_r <= {rx_data, lowByte_r};
        pending_r  <= 1'b1;
      end else if (startWr_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end

      if (dropWord_s) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end

      case (state_r)
        IDLE: begin
          if (startWr_s) begin
            dq_out  <= holdWord_r;
            state_r <= SETUP;
            ce_n    <= 1'b0;
            ub_n    <= 1'b0;
            lb_n    <= 1'b0;
            dq_oe   <= 1'b1;
            we_n    <= 1'b1;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        SETUP: begin
          state_r <= PULSE;
          we_n    <= 1'b0;
          cnt_r   <= '0;
        end
        PULSE: begin
          if (cnt_r == CNT_W'(WR_CYCLES - 1)) begin
            state_r <= HOLD;
            we_n    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        HOLD: begin
          state_r <= REC;
          ce_n    <= 1'b1;
          dq_oe   <= 1'b0;
          ub_n    <= 1'b1;
          lb_n    <= 1'b1;
          cnt_r   <= '0;
        end
        REC: begin
          if (cnt_r == CNT_W'(REC_CYCLES - 1)) begin
            address <= nextAddr_s;
            if (nextAddr_s == ADDR_W'(END_ADDR)) begin
              done <= 1'b1;
            end else begin
              done <= done;
            end
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          ce_n    <= 1'b1;
          we_n    <= 1'b1;
          ub_n    <= 1'b1;
          lb_n    <= 1'b1;
          dq_oe   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ram_writer.sv
// Directed self-checking bench for uart_ram_writer (default instance plus an
// END_ADDR=2 instance for the completion boundary).
module tb_uart_ram_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_valid2;

  logic [25:0] address,  address2;
  logic [15:0] dq_out,   dq_out2;
  logic        dq_oe, ce_n, we_n, oe_n, ub_n, lb_n, adv_n, cre, ram_clk, busy, done, overrun;
  logic        dq_oe2, ce_n2, we_n2, oe_n2, ub_n2, lb_n2, adv_n2, cre2, ram_clk2, busy2, done2, overrun2;

  int testCnt = 0;
  int failCnt = 0;

  logic [41:0] wrQ[$];
  logic [41:0] wrQ2[$];

  always #5 clk = ~clk;

  uart_ram_writer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_data(rx_data), .rx_valid(rx_valid),
    .address(address), .dq_out(dq_out), .dq_oe(dq_oe), .ce_n(ce_n), .we_n(we_n),
    .oe_n(oe_n), .ub_n(ub_n), .lb_n(lb_n), .adv_n(adv_n), .cre(cre),
    .ram_clk(ram_clk), .busy(busy), .done(done), .overrun(overrun)
  );

  uart_ram_writer #(.END_ADDR(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_data(rx_data), .rx_valid(rx_valid2),
    .address(address2), .dq_out(dq_out2), .dq_oe(dq_oe2), .ce_n(ce_n2), .we_n(we_n2),
    .oe_n(oe_n2), .ub_n(ub_n2), .lb_n(lb_n2), .adv_n(adv_n2), .cre(cre2),
    .ram_clk(ram_clk2), .busy(busy2), .done(done2), .overrun(overrun2)
  );

  // Record each completed write (address, data) at the rising edge of we_n.
  always @(posedge we_n) begin
    if (rst_n === 1'b1) wrQ.push_back({address, dq_out});
  end

  always @(posedge we_n2) begin
    if (rst_n === 1'b1) wrQ2.push_back({address2, dq_out2});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic sendByte2(input logic [7:0] b);
    rx_data   = b;
    rx_valid2 = 1'b1;
    tick();
    rx_valid2 = 1'b0;
  endtask

  task automatic popWrite(output logic [41:0] w);
    if (wrQ.size() > 0) w = wrQ.pop_front();
    else w = 'x;
  endtask

  task automatic popWrite2(output logic [41:0] w);
    if (wrQ2.size() > 0) w = wrQ2.pop_front();
    else w = 'x;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    tick();
    wrQ.delete();
    wrQ2.delete();
  endtask

  initial begin
    logic [41:0] w;
    int weLow;
    int ceLow;
    bit seenBusy;
    bit gotPulse;

    rst_n     = 1'b0;
    en        = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
    idle(3);

    // Reset values
    chk("rst_address", 64'(address), 64'd0);
    chk("rst_dq_out", 64'(dq_out), 64'd0);
    chk("rst_dq_oe", 64'(dq_oe), 64'd0);
    chk("rst_strobes", 64'({ce_n, we_n, oe_n, ub_n, lb_n}), 64'h1F);
    chk("rst_async_pins", 64'({adv_n, cre, ram_clk}), 64'd0);
    chk("rst_flags", 64'({busy, done, overrun}), 64'd0);
    rst_n = 1'b1;
    idle(5);
    chk("idle_busy", 64'(busy), 64'd0);

    // Single word 0x1234
    doReset();
    sendByte(8'h34);
    sendByte(8'h12);
    chk("lat_pending_still_idle", 64'(busy), 64'd0);
    tick();
    chk("setup_strobes", 64'({ce_n, we_n, dq_oe, ub_n, lb_n}), 64'b01100);
    chk("setup_data", 64'(dq_out), 64'h1234);
    chk("setup_addr", 64'(address), 64'd0);
    tick();
    chk("pulse_we_fall", 64'(we_n), 64'd0);
    weLow = 1; ceLow = 2; seenBusy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (we_n == 1'b0) weLow++;
      if (ce_n == 1'b0) ceLow++;
      if (busy == 1'b0) break;
    end
    chk("single_we_low_cycles", 64'(weLow), 64'd8);
    chk("single_ce_low_cycles", 64'(ceLow), 64'd10);
    chk("single_addr_after", 64'(address), 64'd1);
    chk("single_busy_after", 64'(busy), 64'd0);
    chk("single_dq_oe_after", 64'(dq_oe), 64'd0);
    popWrite(w);
    chk("single_write", 64'(w), 64'({26'd0, 16'h1234}));

    // Two words, bytes spaced two cycles apart
    doReset();
    sendByte(8'h78); idle(1);
    sendByte(8'h56); idle(1);
    sendByte(8'hBC); idle(1);
    sendByte(8'h9A);
    idle(40);
    popWrite(w);
    chk("two_write0", 64'(w), 64'({26'd0, 16'h5678}));
    popWrite(w);
    chk("two_write1", 64'(w), 64'({26'd1, 16'h9ABC}));
    chk("two_overrun", 64'(overrun), 64'd0);
    chk("two_addr", 64'(address), 64'd2);

    // Three words on consecutive cycles: third one is dropped
    doReset();
    sendByte(8'h01); sendByte(8'h02);
    sendByte(8'h03); sendByte(8'h04);
    sendByte(8'h05); sendByte(8'h06);
    idle(40);
    popWrite(w);
    chk("three_write0", 64'(w), 64'({26'd0, 16'h0201}));
    popWrite(w);
    chk("three_write1", 64'(w), 64'({26'd1, 16'h0403}));
    chk("three_no_extra", 64'(wrQ.size()), 64'd0);
    chk("three_overrun", 64'(overrun), 64'd1);
    chk("three_addr", 64'(address), 64'd2);

    // END_ADDR=2 instance: third word ignored after done
    doReset();
    sendByte2(8'h11); sendByte2(8'h22); idle(20);
    chk("end_done_early", 64'(done2), 64'd0);
    sendByte2(8'h33); sendByte2(8'h44); idle(20);
    chk("end_done_set", 64'(done2), 64'd1);
    sendByte2(8'h55); sendByte2(8'h66); idle(20);
    popWrite2(w);
    chk("end_write0", 64'(w), 64'({26'd0, 16'h2211}));
    popWrite2(w);
    chk("end_write1", 64'(w), 64'({26'd1, 16'h4433}));
    chk("end_no_third", 64'(wrQ2.size()), 64'd0);
    chk("end_addr_hold", 64'(address2), 64'd2);
    chk("end_done_sticky", 64'({done2, busy2}), 64'b10);

    // en drop discards the half-received pair
    doReset();
    sendByte(8'hAA);
    en = 1'b0;
    tick();
    en = 1'b1;
    sendByte(8'h11);
    sendByte(8'h22);
    idle(20);
    popWrite(w);
    chk("en_write", 64'(w), 64'({26'd0, 16'h2211}));
    chk("en_no_extra", 64'(wrQ.size()), 64'd0);
    chk("en_addr", 64'(address), 64'd1);

    // Asynchronous reset during PULSE
    doReset();
    sendByte(8'hEF);
    sendByte(8'hBE);
    gotPulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (we_n == 1'b0) begin
        gotPulse = 1'b1;
        break;
      end
    end
    chk("arst_reached_pulse", 64'(gotPulse), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we_n", 64'(we_n), 64'd1);
    chk("arst_strobes", 64'({ce_n, ub_n, lb_n, dq_oe, busy}), 64'b11100);
    idle(2);
    rst_n = 1'b1;
    idle(20);
    chk("arst_no_write", 64'(wrQ.size()), 64'd0);
    chk("arst_addr", 64'(address), 64'd0);
    chk("arst_busy_after", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/uart_ram_writer.md
# uart_ram_writer

Write-direction counterpart to the PSRAM-to-UART dump path. Takes the byte stream from `uart_top` (`o_rx_data`/`o_rx_valid`), packs byte pairs into 16-bit words (low byte first) and stores them in sequential addresses of the board's cellular RAM using asynchronous write cycles. The board loads a memory image over the serial link, which the existing read path can then dump back for comparison.

## Interface
Parameters:
- `ADDR_W`, 26: RAM word-address width (drives pins A[26:1]).
- `END_ADDR`, 536000: number of words to write. Writing stops after address `END_ADDR-1`.
- `WR_CYCLES`, 8: `we_n` low-pulse length in clk cycles. 80 ns at 100 MHz, which is at least the 70 ns tWP.
- `REC_CYCLES`, 1: `ce_n`/`we_n` high recovery cycles between writes.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: enable (board switch). Must be synchronised externally.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: single-cycle strobe, `rx_data` valid.
- `address` out ADDR_W: RAM word address.
- `dq_out` out 16: write data to RAM DQ.
- `dq_oe` out 1: 1 = drive DQ bus (tristate control at top level).
- `ce_n`, `we_n`, `oe_n`, `ub_n`, `lb_n` out 1 each: RAM strobes, active-low.
- `adv_n`, `cre`, `ram_clk` out 1 each: constant 0, 0, 0 (async mode).
- `busy` out 1: write cycle in progress.
- `done` out 1: sticky. Set when `END_ADDR` words have been written.
- `overrun` out 1: sticky. Set when a word was dropped.

## Operation
- Reset values:
  - `address`=0, `dq_out`=0, `dq_oe`=0.
  - `ce_n`=`we_n`=`oe_n`=1, `ub_n`=`lb_n`=1.
  - `busy`=0, `done`=0, `overrun`=0.
  - Byte phase=0, pending flag=0, FSM=IDLE.
- Byte assembler:
  - On `rx_valid`&`en`&~`done` with phase=0: latch `rx_data` to low byte, phase←1.
  - With phase=1: form word {`rx_data`, low}, phase←0, present the word to the holding register.
- Holding register (1 word):
  - If the FSM is IDLE, or the register is empty, the word is accepted and `pending`←1.
  - If `pending`=1 and the FSM is not IDLE when a new word completes, the new word is dropped and `overrun`←1.
- FSM states: IDLE, SETUP, PULSE, HOLD, REC.
  - IDLE: if `pending`, load `dq_out`←word, clear `pending`, go to SETUP.
  - SETUP (1 cycle): `ce_n`=0, `ub_n`=`lb_n`=0, `dq_oe`=1, `we_n`=1.
  - PULSE (WR_CYCLES cycles): `we_n`=0. All other strobes as in SETUP.
  - HOLD (1 cycle): `we_n`=1, `ce_n`=0, data still driven.
  - REC (REC_CYCLES cycles): `ce_n`=1, `dq_oe`=0, `ub_n`=`lb_n`=1. At the end of REC, `address`←`address`+1.
    - If the new address equals `END_ADDR`, set `done`=1.
    - Return to IDLE.
- `oe_n`=1 at all times.
- `busy`=1 in every state except IDLE.
- `en` low: phase←0, so a half-received byte pair is discarded. A write cycle already in progress completes. A pending word is still written.
- After `done`=1, all bytes are ignored and `address` holds at `END_ADDR`. Only `rst_n` clears `done`.
- The address counter is an ADDR_W-bit unsigned count. It never wraps, because it stops at `END_ADDR`.

## Timing
- Latency: the second `rx_valid` is at cycle t. `pending` sets at t+1. SETUP occurs at t+2, and `we_n` falls at t+3.
- Full write cycle: 1+WR_CYCLES+1+REC_CYCLES = 11 cycles with defaults. Back-to-back words are therefore spaced 11 cycles apart (plus 1 for IDLE).
- Address and data are stable from SETUP through HOLD. This covers tAS, tDW and tDH.
- A byte and word-completion in the same cycle as an IDLE→SETUP transition: the new word goes into the now-empty holding register. This is not an overrun.
- `rst_n` assertion mid-cycle (e.g. during PULSE): all outputs take reset values immediately, without waiting for clk. `we_n` rises asynchronously. The interrupted word is lost.

## Test plan
- Reset: hold `rst_n`=0 → every output at its reset value. Release → `busy` stays 0 with no rx activity.
- Single word: `rx_valid` with 0x34, then 0x12 → `dq_out`=0x1234 at `address`=0, `we_n` low for exactly 8 cycles, `ce_n` low for 10 cycles, `address`=1 after REC, `busy`=0.
- Two words, bytes spaced 2 cycles apart → both written, to addresses 0 and 1, `overrun`=0.
- Three words, byte-pairs on consecutive cycles → first word written, second held pending, third dropped, `overrun`=1. Addresses 0 and 1 written.
- `END_ADDR`=2: send 3 words spaced slowly → `done`=1 after the second write, third word not written, `address`=2.
- Send 0xAA, drop `en` for 1 cycle, raise it, send 0x11, 0x22 → word 0x2211 written. Separately, pulse `rst_n` low during PULSE → `we_n`=1 immediately.
